// File: rtl/exec_mem_pkg.sv
// Shared encodings for the execute/memory back end and its ALU.
// ALU op codes, writeback source selects and the stage FSM states.
package exec_mem_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_param.sv
// Combinational XLEN-wide ALU with zero flag; zero latency, no backpressure.
// Unlisted op codes produce 0 so the branch unit sees a defined Zero.
module alu_param
    import exec_mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] y,
    output logic            zero
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/exec_mem_stage.sv
// Multi-cycle execute/memory/writeback stage: one instruction in flight at a time.
// Latency 1 cycle for ALU/link ops, MEM_LATENCY+2 for loads/stores; holds Result until out_ready.
module exec_mem_stage
    import exec_mem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int MEM_DEPTH   = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [2:0]      ALUControl,
    input  logic            ALUSrc,
    input  logic            MemWrite,
    input  logic [1:0]      ResultSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Result,
    output logic            zero,
    output logic            misaligned
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (MEM_LATENCY > 0) ? $clog2(MEM_LATENCY + 1) : 1;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [AW-1:0]     addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              memwrite_q;
    logic              load_q;
    logic [XLEN-1:0]   mem [MEM_DEPTH];

    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   alu_y;
    logic              alu_zero;
    logic              is_mem;
    logic              ram_we;

    assign src_b  = ALUSrc ? ImmExt : WriteData;
    assign is_mem = MemWrite | (ResultSrc == RES_MEM);

    alu_param #(.XLEN(XLEN)) u_alu (
        .a    (SrcA),
        .b    (src_b),
        .op   (ALUControl),
        .y    (alu_y),
        .zero (alu_zero)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Reset also gates the write so an aborted store never lands in the RAM.
    assign ram_we = (state == ST_MEM) && (cnt == '0) && memwrite_q && !reset;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            memwrite_q <= 1'b0;
            load_q     <= 1'b0;
            Result     <= '0;
            zero       <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        zero       <= alu_zero;
                        misaligned <= is_mem && (alu_y[1:0] != 2'b00);
                        Result     <= (ResultSrc == RES_PC4) ? PCPlus4 : alu_y;
                        addr_q     <= alu_y[AW+1:2];
                        wdata_q    <= WriteData;
                        memwrite_q <= MemWrite;
                        load_q     <= (ResultSrc == RES_MEM);
                        cnt        <= CW'(MEM_LATENCY);
                        state      <= is_mem ? ST_MEM : ST_DONE;
                    end
                end
                ST_MEM: begin
                    if (cnt == '0) begin
                        if (load_q) begin
                            Result <= mem[addr_q];
                        end
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_mem_stage.sv
// Randomized bench for exec_mem_stage against a word-array memory model and plain-arithmetic ALU.
// Directed literal cases pin the model; a negedge monitor checks every DONE cycle.
module tb_exec_mem_stage;
    import exec_mem_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] SrcA, WriteData, ImmExt, PCPlus4;
    logic [2:0]      ALUControl;
    logic            ALUSrc, MemWrite;
    logic [1:0]      ResultSrc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;
    logic            zero, misaligned;

    exec_mem_stage #(.XLEN(XLEN), .MEM_DEPTH(DEPTH), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .WriteData  (WriteData),
        .ImmExt     (ImmExt),
        .PCPlus4    (PCPlus4),
        .ALUControl (ALUControl),
        .ALUSrc     (ALUSrc),
        .MemWrite   (MemWrite),
        .ResultSrc  (ResultSrc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .zero       (zero),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mm [DEPTH];
    logic        cur_vld = 1'b0;
    logic [31:0] cur_res;
    logic        cur_zero, cur_mis;
    logic [31:0] got_res;
    logic        got_zero, got_mis;
    int          last_lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Every DONE cycle: outputs must match the model and stay put under backpressure.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            chk("out_valid_expected", {31'b0, cur_vld}, 32'd1);
            chk("done_result", Result, cur_res);
            chk("done_zero", {31'b0, zero}, {31'b0, cur_zero});
            chk("done_misaligned", {31'b0, misaligned}, {31'b0, cur_mis});
            chk("done_in_ready", {31'b0, in_ready}, 32'd0);
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic alusrc,
                         input logic memwrite, input logic [1:0] ressrc, input int hold);
        logic [31:0] b, y;
        logic        memop;
        int          idx, lat, n;
        @(negedge clk);
        chk("in_ready_idle", {31'b0, in_ready}, 32'd1);
        ALUControl = op; SrcA = a; WriteData = wd; ImmExt = imm; PCPlus4 = pc4;
        ALUSrc = alusrc; MemWrite = memwrite; ResultSrc = ressrc; in_valid = 1'b1;
        b     = alusrc ? imm : wd;
        y     = ref_alu(op, a, b);
        memop = memwrite || (ressrc == 2'b01);
        idx   = int'((y >> 2) % DEPTH);
        cur_res  = (ressrc == 2'b01) ? mm[idx] : (ressrc == 2'b10) ? pc4 : y;
        cur_zero = (y == 32'd0);
        cur_mis  = memop && (y % 4 != 0);
        lat      = memop ? LAT + 2 : 1;
        if (memwrite) mm[idx] = wd;
        @(posedge clk);
        #1 in_valid = 1'b0;
        cur_vld = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        last_lat = n;
        chk("latency", n, lat);
        got_res = Result; got_zero = zero; got_mis = misaligned;
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            SrcA     = $urandom;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        cur_vld = 1'b0;
        @(negedge clk);
        chk("idle_after_release", {30'b0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; WriteData = '0; ImmExt = '0; PCPlus4 = '0;
        ALUControl = '0; ALUSrc = 1'b0; MemWrite = 1'b0; ResultSrc = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", Result, 32'd0);
        chk("rst_zero_mis", {30'b0, zero, misaligned}, 32'd0);
        reset = 1'b0;

        // Give every RAM word a known value so any later load is predictable.
        for (int i = 0; i < DEPTH; i++)
            issue(ALU_ADD, 32'(i * 4), $urandom, 32'd0, 32'd0, 1'b1, 1'b1, RES_ALU, 0);

        issue(ALU_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, RES_ALU, 0);
        chk("add_res", got_res, 32'd12);
        chk("add_zero", {31'b0, got_zero}, 32'd0);
        chk("add_lat", last_lat, 32'd1);
        issue(ALU_SUB, 32'd9, 32'd3, 32'd9, 32'd0, 1'b1, 1'b0, RES_ALU, 0);
        chk("sub_res", got_res, 32'd0);
        chk("sub_zero", {31'b0, got_zero}, 32'd1);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, RES_ALU, 0);
        chk("slt_res", got_res, 32'd1);

        issue(ALU_ADD, 32'h10, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b1, 1'b1, RES_ALU, 0);
        chk("store_lat", last_lat, 32'd4);
        chk("store_res", got_res, 32'h10);
        issue(ALU_ADD, 32'h10, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, RES_MEM, 5);
        chk("load_res", got_res, 32'hDEAD_BEEF);
        issue(ALU_ADD, 32'h10 + 4 * DEPTH, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, RES_MEM, 0);
        chk("load_wrap", got_res, 32'hDEAD_BEEF);
        issue(ALU_ADD, 32'h13, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, RES_MEM, 0);
        chk("load_mis_res", got_res, 32'hDEAD_BEEF);
        chk("load_mis_flag", {31'b0, got_mis}, 32'd1);
        issue(ALU_ADD, 32'h13, 32'd0, 32'd0, 32'h104, 1'b1, 1'b0, RES_PC4, 0);
        chk("link_res", got_res, 32'h104);
        chk("link_mis", {31'b0, got_mis}, 32'd0);

        // Reset in the first MEM cycle of a store must leave the old word intact.
        issue(ALU_ADD, 32'h20, 32'h1234_5678, 32'd0, 32'd0, 1'b1, 1'b1, RES_ALU, 0);
        @(negedge clk);
        SrcA = 32'h20; ImmExt = 32'd0; ALUSrc = 1'b1; ALUControl = ALU_ADD;
        WriteData = 32'h55; MemWrite = 1'b1; ResultSrc = RES_ALU; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", Result, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        issue(ALU_ADD, 32'h20, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, RES_MEM, 0);
        chk("midrst_old_word", got_res, 32'h1234_5678);

        for (int k = 0; k < 80; k++) begin
            logic [31:0] a, wd, imm;
            logic [1:0]  rs;
            logic        mw;
            a   = $urandom;
            wd  = $urandom;
            imm = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                imm = a;
                wd  = a;
            end
            rs = 2'($urandom_range(0, 3));
            mw = (rs != RES_MEM) && ($urandom_range(0, 2) == 0);
            issue(3'($urandom_range(0, 7)), a, wd, imm, $urandom, 1'($urandom_range(0, 1)),
                  mw, rs, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exec_mem_stage.md
Name: exec_mem_stage

Overview:
- Parametrised, multi-cycle successor to the single-cycle execute/memory/writeback back end.
- Performs these steps for one instruction at a time under a valid/ready handshake:
  - selects SrcB;
  - runs the ALU;
  - accesses a word-addressed data RAM with a configurable wait-state latency;
  - selects the writeback Result.
- Sits between register-file read and register-file write in the multi-cycle core.

Parameters:
- XLEN, 32, datapath width in bits (≥8).
- MEM_DEPTH, 64, data RAM depth in words; must be a power of 2.
- MEM_LATENCY, 2, extra wait cycles per load/store (0 allowed).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- in_valid  in  1  operands/controls valid.
- in_ready  out  1  stage can accept.
- SrcA  in  XLEN  ALU operand A.
- WriteData  in  XLEN  rs2 value; SrcB when ALUSrc=0; store data.
- ImmExt  in  XLEN  immediate; SrcB when ALUSrc=1.
- PCPlus4  in  XLEN  link value.
- ALUControl  in  3  ALU op.
- ALUSrc  in  1  SrcB select.
- MemWrite  in  1  store.
- ResultSrc  in  2  00 ALU, 01 load, 10 PCPlus4, 11 reserved (treated as ALU).
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer accepts.
- Result  out  XLEN  writeback value.
- zero  out  1  registered ALUResult==0.
- misaligned  out  1  load/store address bits[1:0]≠0.

Behaviour:
- One clock domain; reset is asynchronous and active-high; the clock port is clk and the reset port is reset.
- ALU ops:
  - 000 add; 001 sub; 010 and; 011 or; 101 signed slt (result 1 or 0).
  - Other codes yield 0.
  - All arithmetic is modulo 2^XLEN; overflow is ignored.
- States:
  - IDLE: in_ready=1.
    - On in_valid, capture ALUResult, WriteData, PCPlus4, ResultSrc, MemWrite, zero and misaligned.
    - Mem op (MemWrite=1 or ResultSrc=01): load wait counter with MEM_LATENCY, go to MEM.
    - Otherwise: go to DONE.
  - MEM: in_ready=0.
    - Counter decrements each cycle.
    - In the cycle the counter equals 0:
      - store: write RAM[addr] with WriteData (exactly one write);
      - load: capture RAM[addr] into Result.
    - Then go to DONE.
    - Total MEM residency is MEM_LATENCY+1 cycles.
  - DONE: out_valid=1; Result, zero and misaligned stay stable.
    - On out_ready, go to IDLE.
    - No new instruction is accepted in the same cycle.
- Latency, from the in_valid accept edge to out_valid:
  - ALU or link op: 1 cycle.
  - Mem op: MEM_LATENCY+2 cycles.
- Result by ResultSrc:
  - 00 or 11: ALUResult.
  - 10: PCPlus4.
  - 01: load data.
  - For a store, Result is ALUResult, so the consumer can ignore it.
- Address handling:
  - addr = ALUResult[log2(MEM_DEPTH)+1:2].
  - Upper bits are dropped, so out-of-range addresses wrap modulo MEM_DEPTH.
  - Low bits are ignored for the access, but misaligned is set (mem ops only; 0 for non-mem ops).
- RAM: synchronous write, combinational read. Contents are not cleared by reset and are undefined at power-up.
- Reset values: state IDLE; in_ready=1; out_valid=0; Result=0; zero=0; misaligned=0; counter=0.
- Reset during MEM aborts the pending access; a pending store must not write the RAM.
- Reset during DONE discards the result.
- in_valid is ignored outside IDLE; inputs are sampled only at the accept edge.
- out_ready is ignored outside DONE.

Decomposition:
- Shared package exec_mem_pkg:
  - ALU op constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT.
  - ResultSrc constants: RES_ALU, RES_MEM, RES_PC4.
  - State enum: ST_IDLE, ST_MEM, ST_DONE.
- One sub-module, alu_param (XLEN): combinational ALU with a Zero output, reusable by the branch unit.
- RAM, muxes, counter and FSM are inline.

Test Plan:
- Add: SrcA=5, WriteData=7, ALUSrc=0, ALUControl=000, ResultSrc=00 → out_valid 1 cycle after accept; Result=12; zero=0.
- Sub to zero: SrcA=9, ImmExt=9, ALUSrc=1, op 001 → Result=0, zero=1. SLT with SrcA=-1, SrcB=1 → Result=1.
- Store, then load (MEM_LATENCY=2):
  - Store addr 0x10, data 0xDEADBEEF → out_valid 4 cycles after accept.
  - Load addr 0x10, ResultSrc=01 → Result=0xDEADBEEF.
  - Load addr 0x10+4*MEM_DEPTH → same value (wrap).
- Backpressure: hold out_ready=0 for 5 cycles in DONE → Result, zero and out_valid stable; in_ready=0; a new in_valid is ignored. Raise out_ready → IDLE the next cycle.
- Misaligned and link:
  - Load at 0x13 → reads word 0x10; misaligned=1.
  - ResultSrc=10, PCPlus4=0x104 → Result=0x104; misaligned=0.
- Reset mid-store: assert reset in the first MEM cycle of a store of 0x55 to addr 0x20 → outputs reset immediately. A later load from 0x20 returns the old contents, not 0x55.
